// File: rtl/phase_sequencer.sv
// Sequences the enabled sink-list stages in index order via en/start/done and
// grants the shared memory port to the active stage. Optional watchdog: PHASE_SEQ_TIMEOUT_EN.
module phase_sequencer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 16
`ifdef PHASE_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                         clock,
  input  logic                         nrst,
  input  logic                         go,
  input  logic [NUM_STAGES-1:0]        stage_mask,
  output logic                         busy,
  output logic                         done_all,
  output logic [((NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1)-1:0] cur_stage,
  output logic                         timeout_err,
  output logic [NUM_STAGES-1:0]        stage_en,
  output logic [NUM_STAGES-1:0]        stage_start,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
  input  logic [NUM_STAGES-1:0]        stage_wr_en,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wr_en,
  output logic [DATA_W-1:0]            mem_wdata
);

  localparam int unsigned CUR_W = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [NUM_STAGES-1:0]   mask_q;
  logic [NUM_STAGES-1:0]   mask_nxt;
  logic [CUR_W-1:0]        cur_nxt;
  logic                    first_found;
  logic [CUR_W-1:0]        first_idx;
  logic                    above_found;
  logic [CUR_W-1:0]        above_idx;
  logic                    busy_nxt;
  logic                    done_all_nxt;
  logic [NUM_STAGES-1:0]   en_nxt;
  logic [NUM_STAGES-1:0]   start_nxt;
  logic                    granted;

`ifdef PHASE_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_hit;
`endif

  // Lowest set bit of the incoming mask, and lowest captured bit above cur_stage
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    above_found = 1'b0;
    above_idx   = '0;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      if (!first_found && stage_mask[s]) begin
        first_found = 1'b1;
        first_idx   = CUR_W'(s);
      end
      if (!above_found && mask_q[s] && (s > int'(cur_stage))) begin
        above_found = 1'b1;
        above_idx   = CUR_W'(s);
      end
    end
  end

  // State register plus registered outputs
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      cur_stage   <= '0;
      busy        <= 1'b0;
      done_all    <= 1'b0;
      stage_en    <= '0;
      stage_start <= '0;
    end else begin
      state       <= state_nxt;
      mask_q      <= mask_nxt;
      cur_stage   <= cur_nxt;
      busy        <= busy_nxt;
      done_all    <= done_all_nxt;
      stage_en    <= en_nxt;
      stage_start <= start_nxt;
    end
  end

  // Next-state logic; done is only honoured in WAIT since it may be stale elsewhere
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_stage;
    mask_nxt  = mask_q;
`ifdef PHASE_SEQ_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (go) begin
          mask_nxt = stage_mask;
          if (first_found) begin
            cur_nxt   = first_idx;
            state_nxt = ST_ARM;
          end else begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_ARM:   state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (stage_done[cur_stage]) begin
          state_nxt = ST_NEXT;
        end
`ifdef PHASE_SEQ_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_FIN;
        end
`endif
      end
      ST_NEXT: begin
        if (above_found) begin
          cur_nxt   = above_idx;
          state_nxt = ST_ARM;
        end else begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: pulses computed from the upcoming state, memory mux from the current grant
  always_comb begin
    busy_nxt     = (state_nxt != ST_IDLE);
    done_all_nxt = (state_nxt == ST_FIN);
    en_nxt       = '0;
    start_nxt    = '0;
    if (state_nxt == ST_ARM) begin
      en_nxt[cur_nxt] = 1'b1;
    end
    if (state_nxt == ST_START) begin
      start_nxt[cur_nxt] = 1'b1;
    end

    granted   = (state == ST_ARM) || (state == ST_START) ||
                (state == ST_WAIT) || (state == ST_NEXT);
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      if (granted && (cur_stage == CUR_W'(s))) begin
        mem_addr  = stage_addr[s*ADDR_W +: ADDR_W];
        mem_wr_en = stage_wr_en[s];
        mem_wdata = stage_wdata[s*DATA_W +: DATA_W];
      end
    end
  end

`ifdef PHASE_SEQ_TIMEOUT_EN
  // WAIT-cycle counter, zero on every WAIT entry
  always_ff @(posedge clock) begin
    if (!nrst) begin
      wait_cnt <= '0;
    end else if (state != ST_WAIT) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_W'(TIMEOUT_CYCLES - 1)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Sticky until the next accepted go
  always_ff @(posedge clock) begin
    if (!nrst) begin
      timeout_err <= 1'b0;
    end else if ((state == ST_IDLE) && go) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: queue-based run model compared every cycle, directed
// scenarios with hand-computed timings, then randomized runs.
module tb_phase_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;
`ifdef PHASE_SEQ_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`endif

  logic              clock = 1'b0;
  logic              nrst;
  logic              go;
  logic [N-1:0]      stage_mask;
  logic              busy;
  logic              done_all;
  logic [1:0]        cur_stage;
  logic              timeout_err;
  logic [N-1:0]      stage_en;
  logic [N-1:0]      stage_start;
  logic [N-1:0]      stage_done;
  logic [N*AW-1:0]   stage_addr;
  logic [N-1:0]      stage_wr_en;
  logic [N*DW-1:0]   stage_wdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_wr_en;
  logic [DW-1:0]     mem_wdata;

  always #5 clock = ~clock;

`ifdef PHASE_SEQ_TIMEOUT_EN
  phase_sequencer #(.NUM_STAGES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
`else
  phase_sequencer #(.NUM_STAGES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
`endif
    .clock(clock), .nrst(nrst), .go(go), .stage_mask(stage_mask),
    .busy(busy), .done_all(done_all), .cur_stage(cur_stage), .timeout_err(timeout_err),
    .stage_en(stage_en), .stage_start(stage_start), .stage_done(stage_done),
    .stage_addr(stage_addr), .stage_wr_en(stage_wr_en), .stage_wdata(stage_wdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Run model: pending stages as a queue, progress within the granted stage as an age
  bit m_active, m_fin, m_gap, m_tmo;
  int m_cur, m_age;
  int m_pend[$];

  // Stage models
  bit [N-1:0] done_q;
  int cnt[N];
  int clr_pend[N];
  int lag_cfg[N];
  int dly[N];
  bit hold[N];
  assign stage_done = done_q;

  // Per-run event log
  int go_cyc;
  int en_at[N];
  int start_at[N];
  int en_n[N];
  int cur_at_en[N];
  int done_at;
  int done_n;
  bit [63:0] busy_log;
`ifdef PHASE_SEQ_TIMEOUT_EN
  logic tmo_at_done;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]  e_en;
    logic [N-1:0]  e_start;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_wr;
    bit            granted;
    granted = m_active && !m_fin;
    e_en    = (granted && !m_gap && m_age == 0) ? (N'(1) << m_cur) : '0;
    e_start = (granted && !m_gap && m_age == 1) ? (N'(1) << m_cur) : '0;
    e_addr  = granted ? stage_addr[m_cur*AW +: AW] : '0;
    e_wdata = granted ? stage_wdata[m_cur*DW +: DW] : '0;
    e_wr    = granted ? stage_wr_en[m_cur] : 1'b0;
    chk("busy", 32'(busy), 32'(m_active));
    chk("done_all", 32'(done_all), 32'(m_fin));
    chk("cur_stage", 32'(cur_stage), 32'(m_cur));
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    chk("stage_en", 32'(stage_en), 32'(e_en));
    chk("stage_start", 32'(stage_start), 32'(e_start));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
  endtask

  task automatic model_step();
    if (!nrst) begin
      m_active = 0; m_fin = 0; m_gap = 0; m_tmo = 0; m_cur = 0; m_age = 0;
      m_pend.delete();
    end else if (m_fin) begin
      m_fin = 0; m_active = 0;
    end else if (!m_active) begin
      if (go) begin
        m_tmo = 0;
        m_active = 1;
        m_pend.delete();
        for (int s = 0; s < int'(N); s++) if (stage_mask[s]) m_pend.push_back(s);
        if (m_pend.size() == 0) m_fin = 1;
        else begin m_cur = m_pend.pop_front(); m_age = 0; m_gap = 0; end
      end
    end else if (m_gap) begin
      m_gap = 0;
      if (m_pend.size() > 0) begin m_cur = m_pend.pop_front(); m_age = 0; end
      else m_fin = 1;
    end else if (m_age >= 2 && stage_done[m_cur]) begin
      m_gap = 1;
    end
`ifdef PHASE_SEQ_TIMEOUT_EN
    else if (m_age == int'(TMO) + 1) begin
      m_fin = 1; m_tmo = 1; m_pend.delete();
    end
`endif
    else begin
      m_age++;
    end
  endtask

  task automatic stage_update(input bit rst_edge);
    for (int s = 0; s < int'(N); s++) begin
      if (rst_edge) begin
        done_q[s] = 1'b0; cnt[s] = 0; clr_pend[s] = 0;
      end else begin
        if (clr_pend[s] > 0) begin
          clr_pend[s]--;
          if (clr_pend[s] == 0) done_q[s] = 1'b0;
        end
        if (stage_en[s] === 1'b1) begin
          if (lag_cfg[s] == 0) done_q[s] = 1'b0;
          else clr_pend[s] = lag_cfg[s];
        end
        if (cnt[s] > 0) begin
          cnt[s]--;
          if (cnt[s] == 0) done_q[s] = 1'b1;
        end
        if (stage_start[s] === 1'b1 && !hold[s]) cnt[s] = dly[s];
      end
    end
  endtask

  task automatic clear_log();
    for (int s = 0; s < int'(N); s++) begin
      en_at[s] = -1; start_at[s] = -1; en_n[s] = 0; cur_at_en[s] = -1;
    end
    done_at = -1; done_n = 0; busy_log = '0;
  endtask

  task automatic cycle();
    int rel;
    bit rst_edge;
    #1;
    compare_all();
    rel = cyc - go_cyc;
    if (rel >= 0 && rel < 64) busy_log[rel] = busy;
    for (int s = 0; s < int'(N); s++) begin
      if (stage_en[s] === 1'b1) begin
        en_n[s]++;
        if (en_at[s] < 0) begin en_at[s] = rel; cur_at_en[s] = int'(cur_stage); end
      end
      if (stage_start[s] === 1'b1 && start_at[s] < 0) start_at[s] = rel;
    end
    if (done_all === 1'b1) begin
      done_n++;
      if (done_at < 0) done_at = rel;
`ifdef PHASE_SEQ_TIMEOUT_EN
      tmo_at_done = timeout_err;
`endif
    end
    model_step();
    rst_edge = !nrst;
    @(posedge clock);
    @(negedge clock);
    stage_update(rst_edge);
    cyc++;
  endtask

  task automatic start_run(input logic [N-1:0] mask);
    stage_mask = mask;
    go = 1'b1;
    go_cyc = cyc;
    clear_log();
    cycle();
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && done_n == 0; k++) cycle();
    if (done_n == 0) begin
      checks++; errors++;
      $display("FAIL run_timeout: no done_all within %0d cycles", budget);
    end
    cycle();
  endtask

  task automatic rand_data();
    for (int s = 0; s < int'(N); s++) begin
      stage_addr[s*AW +: AW]  = AW'($urandom);
      stage_wdata[s*DW +: DW] = DW'($urandom);
    end
    stage_wr_en = N'($urandom);
  endtask

  task automatic set_stage(input int s, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    stage_addr[s*AW +: AW]  = a;
    stage_wr_en[s]          = w;
    stage_wdata[s*DW +: DW] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; go = 1'b0; stage_mask = '0;
    stage_addr = '0; stage_wr_en = '0; stage_wdata = '0;
    done_q = '0; go_cyc = 0;
    for (int s = 0; s < int'(N); s++) begin
      cnt[s] = 0; clr_pend[s] = 0; lag_cfg[s] = 0; dly[s] = 5; hold[s] = 0;
    end
    clear_log();
    m_active = 0; m_fin = 0; m_gap = 0; m_tmo = 0; m_cur = 0; m_age = 0;
    @(posedge clock);
    @(negedge clock);
    cycle();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_en", 32'(stage_en), 0);
    chk("reset_cur", 32'(cur_stage), 0);
    nrst = 1'b1;
    cycle();

    // T1: mask 0101, done 5 cycles after start
    start_run(4'b0101);
    wait_idle(100);
    chk("t1_en0_at", 32'(en_at[0]), 1);
    chk("t1_start0_at", 32'(start_at[0]), 2);
    chk("t1_cur_at_en0", 32'(cur_at_en[0]), 0);
    chk("t1_en2_at", 32'(en_at[2]), 9);
    chk("t1_start2_at", 32'(start_at[2]), 10);
    chk("t1_cur_at_en2", 32'(cur_at_en[2]), 2);
    chk("t1_en1_count", 32'(en_n[1]), 0);
    chk("t1_en3_count", 32'(en_n[3]), 0);
    chk("t1_done_count", 32'(done_n), 1);
    chk("t1_done_at", 32'(done_at), 17);

    // T2: empty mask
    start_run(4'b0000);
    wait_idle(10);
    chk("t2_done_at", 32'(done_at), 1);
    chk("t2_en_total", 32'(en_n[0] + en_n[1] + en_n[2] + en_n[3]), 0);
    chk("t2_busy_c0", 32'(busy_log[0]), 0);
    chk("t2_busy_c1", 32'(busy_log[1]), 1);
    chk("t2_busy_c2", 32'(busy_log[2]), 0);

    // T3: memory mux with competing writers
    for (int s = 0; s < int'(N); s++) set_stage(s, AW'(s + 1), 1'b1, DW'(16'hA000 + s));
    set_stage(0, 11'h248, 1'b1, 16'h5555);
    set_stage(1, 11'h68A, 1'b1, 16'h0011);
    hold[1] = 1;
    #1;
    chk("t3_idle_wr_en", 32'(mem_wr_en), 0);
    chk("t3_idle_addr", 32'(mem_addr), 0);
    start_run(4'b0010);
    cycle(); cycle();
    #1;
    chk("t3_addr", 32'(mem_addr), 32'h68A);
    chk("t3_wr_en", 32'(mem_wr_en), 1);
    chk("t3_wdata", 32'(mem_wdata), 32'h0011);
    hold[1] = 0;
    done_q[1] = 1'b1;
    wait_idle(20);

    // T4: stale done held through ARM/START, go pulsed during WAIT
    done_q[0] = 1'b1;
    lag_cfg[0] = 2;
    start_run(4'b0001);
    cycle(); cycle();
    go = 1'b1; stage_mask = 4'b1111;
    cycle();
    go = 1'b0;
    wait_idle(50);
    chk("t4_done_at", 32'(done_at), 9);
    chk("t4_en0_count", 32'(en_n[0]), 1);
    chk("t4_en_others", 32'(en_n[1] + en_n[2] + en_n[3]), 0);
    chk("t4_done_count", 32'(done_n), 1);
    lag_cfg[0] = 0;

    // T5: reset during WAIT of stage 2
    hold[2] = 1;
    start_run(4'b0100);
    cycle(); cycle(); cycle();
    nrst = 1'b0;
    cycle();
    nrst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_en", 32'(stage_en), 0);
    chk("t5_start", 32'(stage_start), 0);
    chk("t5_cur", 32'(cur_stage), 0);
    chk("t5_done_all", 32'(done_all), 0);
    chk("t5_wr_en", 32'(mem_wr_en), 0);
    cycle(); cycle(); cycle();
    chk("t5_no_done", 32'(done_n), 0);
    hold[2] = 0;
    start_run(4'b1000);
    wait_idle(50);
    chk("t5_en3_count", 32'(en_n[3]), 1);
    chk("t5_en_others", 32'(en_n[0] + en_n[1] + en_n[2]), 0);
    chk("t5_done_at", 32'(done_at), 9);

`ifdef PHASE_SEQ_TIMEOUT_EN
    // T6: watchdog skips the remaining stages
    hold[0] = 1;
    start_run(4'b0011);
    wait_idle(100);
    chk("t6_done_at", 32'(done_at), 19);
    chk("t6_tmo_at_done", 32'(tmo_at_done), 1);
    chk("t6_en1_count", 32'(en_n[1]), 0);
    chk("t6_tmo_sticky", 32'(timeout_err), 1);
    hold[0] = 0;
    start_run(4'b0001);
    chk("t6_tmo_cleared", 32'(timeout_err), 0);
    wait_idle(50);
`endif

    // Randomized traffic: random masks, go, stage latencies, data and rare resets
    for (int i = 0; i < 3000; i++) begin
      if (busy !== 1'b1) begin
        for (int s = 0; s < int'(N); s++) begin
          dly[s] = int'($urandom_range(1, 20));
          lag_cfg[s] = int'($urandom_range(0, 2));
        end
      end
      rand_data();
      go = ($urandom_range(0, 3) == 0);
      stage_mask = N'($urandom);
      nrst = ($urandom_range(0, 199) != 0);
      cycle();
    end
    nrst = 1'b1;
    go = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
